// File: rtl/y_response_misr.sv
// Response-side MISR: folds each valid y sample into a signature and compares it to a golden value.
// Optional `MISR_XCHECK_EN: sticky detection of X/Z on valid samples forces pass low.
module y_response_misr #(
  parameter int                   Y_WIDTH   = 119,
  parameter int                   SIG_WIDTH = 32,
  parameter logic [SIG_WIDTH-1:0] POLY      = 32'h04C11DB7,
  parameter logic [SIG_WIDTH-1:0] SEED      = 32'hFFFFFFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [15:0]          sample_count,
  input  logic [SIG_WIDTH-1:0] expected_sig,
  input  logic                 y_valid,
  input  logic [Y_WIDTH-1:0]   y,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [SIG_WIDTH-1:0] signature,
  output logic [15:0]          samples_seen
);

  localparam int NSLICE = (Y_WIDTH + SIG_WIDTH - 1) / SIG_WIDTH;
  localparam int EXTW   = NSLICE * SIG_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state;
  state_t               stateNext;
  logic [15:0]          target;
  logic [EXTW-1:0]      yExt;
  logic [SIG_WIDTH-1:0] fold;
  logic [SIG_WIDTH-1:0] sigStep;
  logic                 absorb;
  logic                 matchOk;

  // Zero-extend y to a whole number of slices and XOR the slices together.
  always_comb begin
    yExt = EXTW'(y);
    fold = '0;
    for (int i = 0; i < NSLICE; i++) begin
      fold = fold ^ yExt[i*SIG_WIDTH +: SIG_WIDTH];
    end
  end

  always_comb begin
    sigStep = {signature[SIG_WIDTH-2:0], 1'b0}
            ^ (signature[SIG_WIDTH-1] ? POLY : '0)
            ^ fold;
  end

  // A sample arriving together with start belongs to the aborted run and is dropped.
  assign absorb = (state == RUN) && !start && y_valid && (samples_seen != target);

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = RUN;
      RUN: begin
        if (start)                       stateNext = RUN;
        else if (samples_seen == target) stateNext = CHECK;
      end
      CHECK:   stateNext = start ? RUN : DONE;
      DONE:    if (start) stateNext = RUN;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

`ifdef MISR_XCHECK_EN
  logic xz;

  always_ff @(posedge clk) begin
    if (rst || start)              xz <= 1'b0;
    else if (absorb && (^y === 1'bx)) xz <= 1'b1;
  end

  assign matchOk = (signature == expected_sig) && !xz;
`else
  assign matchOk = (signature == expected_sig);
`endif

  // pass is written only in CHECK so the previous verdict stays visible until the next compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      signature    <= SEED;
      samples_seen <= '0;
      target       <= '0;
      pass         <= 1'b0;
    end else if (start) begin
      signature    <= SEED;
      samples_seen <= '0;
      target       <= sample_count;
    end else begin
      if (absorb) begin
        signature <= sigStep;
        if (samples_seen != 16'hFFFF) samples_seen <= samples_seen + 16'd1;
      end
      if (state == CHECK) pass <= matchOk;
    end
  end

  assign busy = (state == RUN) || (state == CHECK);
  assign done = (state == DONE);

endmodule

// File: tb/tb_y_response_misr.sv
// Randomized self-checking bench for y_response_misr against a queue-based signature model.
module tb_y_response_misr;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [15:0]  sample_count;
  logic [31:0]  expected_sig;
  logic         y_valid;
  logic [118:0] y;
  logic         busy;
  logic         done;
  logic         pass;
  logic [31:0]  signature;
  logic [15:0]  samples_seen;

  int total = 0;
  int bad   = 0;

  logic [118:0] sampleQ[$];
  logic [31:0]  lastSig;

  y_response_misr dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .sample_count (sample_count),
    .expected_sig (expected_sig),
    .y_valid      (y_valid),
    .y            (y),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .signature    (signature),
    .samples_seen (samples_seen)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [118:0] randY();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[118:0];
  endfunction

  // Signature of a whole sample list: CRC-style shift of the running value, XOR with the word-folded sample.
  function automatic logic [31:0] modelSig(input logic [118:0] q[$]);
    logic [31:0]  s;
    logic [31:0]  f;
    logic [127:0] w;
    s = 32'hFFFFFFFF;
    foreach (q[n]) begin
      w = {9'b0, q[n]};
      f = 0;
      for (int k = 0; k < 4; k++) f ^= 32'((w >> (32 * k)) & 128'hFFFFFFFF);
      s = ((s << 1) ^ (s[31] ? 32'h04C11DB7 : 32'h0)) ^ f;
    end
    return s;
  endfunction

  // Start a run, feed sampleQ with random gaps, then check latency, signature and verdict.
  task automatic applyStimulus(input int gapPct, input bit wrongExp, input bit validWithStart);
    logic [31:0] want;
    int          idx;
    int          cyc;
    want         = modelSig(sampleQ);
    expected_sig = wrongExp ? (want ^ (32'h1 << $urandom_range(31))) : want;
    sample_count = 16'(sampleQ.size());
    start        = 1'b1;
    y_valid      = validWithStart;
    y            = randY();
    tick();
    start   = 1'b0;
    y_valid = 1'b0;
    checkOutput("busy_after_start", 64'(busy), 64'd1);
    checkOutput("sig_after_start", 64'(signature), 64'hFFFFFFFF);
    checkOutput("seen_after_start", 64'(samples_seen), 64'd0);
    idx = 0;
    while (idx < sampleQ.size()) begin
      y_valid = ($urandom_range(99) >= gapPct);
      y       = y_valid ? sampleQ[idx] : randY();
      if (y_valid) idx++;
      tick();
    end
    y_valid = 1'b0;
    cyc = 0;
    while (!done && cyc < 10) begin
      tick();
      cyc++;
    end
    checkOutput("done_latency", 64'(cyc), 64'd2);
    checkOutput("signature", 64'(signature), 64'(want));
    checkOutput("samples_seen", 64'(samples_seen), 64'(sampleQ.size()));
    checkOutput("pass", 64'(pass), 64'(!wrongExp));
    checkOutput("busy_in_done", 64'(busy), 64'd0);
    lastSig = want;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sample_count = '0; expected_sig = '0; y_valid = 1'b0; y = '0;
    tick();
    tick();
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_pass", 64'(pass), 64'd0);
    checkOutput("rst_sig", 64'(signature), 64'hFFFFFFFF);
    checkOutput("rst_seen", 64'(samples_seen), 64'd0);
    rst = 1'b0;

    // y_valid outside a run must not touch the signature
    y_valid = 1'b1; y = randY();
    tick();
    y_valid = 1'b0;
    checkOutput("idle_sig", 64'(signature), 64'hFFFFFFFF);
    checkOutput("idle_seen", 64'(samples_seen), 64'd0);

    // directed vectors
    sampleQ = {};
    applyStimulus(0, 1'b0, 1'b0);
    sampleQ = {119'h0};
    applyStimulus(0, 1'b0, 1'b0);
    checkOutput("vec_y0", 64'(signature), 64'hFB3EE249);
    sampleQ = {119'h1};
    expected_sig = 32'hFB3EE249;
    applyStimulus(0, 1'b1, 1'b0);
    checkOutput("vec_y1", 64'(signature), 64'hFB3EE248);

    // same four samples gap-free then heavily gapped
    sampleQ = {randY(), randY(), randY(), randY()};
    applyStimulus(0, 1'b0, 1'b0);
    applyStimulus(55, 1'b0, 1'b1);

    // samples in DONE are ignored and the verdict is held
    y_valid = 1'b1; y = randY();
    tick(); tick();
    y_valid = 1'b0;
    checkOutput("done_hold_sig", 64'(signature), 64'(lastSig));
    checkOutput("done_hold_done", 64'(done), 64'd1);

    // abort after two of four samples, then a fresh run
    sample_count = 16'd4; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      y_valid = 1'b1; y = randY();
      tick();
    end
    y_valid = 1'b0;
    checkOutput("abort_seen_mid", 64'(samples_seen), 64'd2);
    sampleQ = {randY(), randY(), randY(), randY()};
    applyStimulus(30, 1'b0, 1'b1);

    // random runs
    for (int r = 0; r < 12; r++) begin
      sampleQ = {};
      for (int n = 0; n < $urandom_range(20); n++) sampleQ.push_back(randY());
      applyStimulus($urandom_range(60), 1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    // reset in the middle of a run after a passing run
    sampleQ = {randY()};
    applyStimulus(0, 1'b0, 1'b0);
    sample_count = 16'd5; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      y_valid = 1'b1; y = randY();
      tick();
    end
    y_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_done", 64'(done), 64'd0);
    checkOutput("midrst_pass", 64'(pass), 64'd0);
    checkOutput("midrst_sig", 64'(signature), 64'hFFFFFFFF);
    checkOutput("midrst_seen", 64'(samples_seen), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
